// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        PAYLOAD,
        CHECK,
        RUN,
        ERROR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// Flags the word on the same cycle its fourth byte is accepted.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_lane;
    logic [31:0] r_shift;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (clear) begin
            r_lane  <= '0;
            r_shift <= '0;
        end else if (byte_valid) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {byte_in, r_shift[31:8]};
        end
    end

    // Byte 0 ends up in bits [7:0] after three right shifts plus the incoming lane 3.
    assign word_valid = byte_valid && (r_lane == 2'd3);
    assign word       = {byte_in, r_shift[31:8]};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checked byte frame, writes words
// to instruction memory and releases the CPU once the image verifies.
module imem_loader
    import loader_pkg::*;
#(
    parameter int                DEPTH_WORDS = 64,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            r_state;
    state_t            w_state_next;
    logic [7:0]        r_n_lo;
    logic [15:0]       r_n;
    logic [15:0]       r_word_idx;
    logic [7:0]        r_xor;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_done;
    logic              r_error;

    logic              w_accept;
    logic              w_pay_byte;
    logic              w_rearm;
    logic [15:0]       w_n_hdr;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic              w_last_word;

    assign w_accept    = in_valid && in_ready;
    assign w_pay_byte  = w_accept && (r_state == PAYLOAD);
    assign w_rearm     = restart && ((r_state == RUN) || (r_state == ERROR));
    assign w_n_hdr     = {in_data, r_n_lo};
    assign w_last_word = w_word_valid && ((r_word_idx + 16'd1) == r_n);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_rearm),
        .byte_valid (w_pay_byte),
        .byte_in    (in_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            HDR_LO: begin
                in_ready = 1'b1;
                if (w_accept) w_state_next = HDR_HI;
            end
            HDR_HI: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (32'(w_n_hdr) > 32'(DEPTH_WORDS)) w_state_next = ERROR;
                    else if (w_n_hdr == 16'd0)           w_state_next = CHECK;
                    else                                 w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                in_ready = 1'b1;
                if (w_last_word) w_state_next = CHECK;
            end
            CHECK: begin
                in_ready = 1'b1;
                if (w_accept) w_state_next = (in_data == r_xor) ? RUN : ERROR;
            end
            RUN, ERROR: begin
                if (restart) w_state_next = HDR_LO;
            end
            default: w_state_next = HDR_LO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= HDR_LO;
            r_n_lo     <= '0;
            r_n        <= '0;
            r_word_idx <= '0;
            r_xor      <= '0;
            r_we       <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_wdata    <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == HDR_LO) && w_accept) r_n_lo <= in_data;
            if ((r_state == HDR_HI) && w_accept) r_n <= w_n_hdr;

            if (w_rearm) begin
                r_word_idx <= '0;
                r_xor      <= '0;
            end else begin
                if (w_pay_byte)   r_xor      <= r_xor ^ in_data;
                if (w_word_valid) r_word_idx <= r_word_idx + 16'd1;
            end

            // Address and data hold their value between writes.
            r_we <= w_word_valid;
            if (w_word_valid) begin
                r_addr  <= BASE_ADDR + ADDR_W'(32'(r_word_idx) * BYTES_PER_WORD);
                r_wdata <= w_word;
            end

            r_hold  <= (w_state_next != RUN);
            r_done  <= (w_state_next == RUN);
            r_error <= (w_state_next == ERROR);
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames checked
// against a frame-level model computed from the byte stream itself.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int checks   = 0;
    int errors   = 0;
    int n_writes = 0;
    logic prev_we = 1'b0;
    logic [7:0] frame[$];

    imem_loader #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Every write pulse must be isolated and happen while the core is still held.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            chk("we_single_cycle", {31'b0, prev_we}, 32'd0);
            chk("hold_during_write", {31'b0, cpu_hold}, 32'd1);
        end
        prev_we = imem_we;
    end

    // ---------------- frame-level reference model ----------------
    function automatic int model_n();
        return int'({frame[1], frame[0]});
    endfunction

    function automatic int model_writes();
        int n;
        n = model_n();
        return (n > DEPTH) ? 0 : n;
    endfunction

    function automatic logic model_ok();
        int n;
        logic [7:0] x;
        n = model_n();
        if (n > DEPTH) return 1'b0;
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x = x ^ frame[2 + i];
        return frame[2 + 4 * n] == x;
    endfunction

    function automatic logic [31:0] model_word(input int k);
        return {frame[2 + 4*k + 3], frame[2 + 4*k + 2], frame[2 + 4*k + 1], frame[2 + 4*k]};
    endfunction

    task automatic build_random(input int n, input logic good);
        logic [7:0] x;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame.push_back(b);
        end
        frame.push_back(good ? x : (x ^ 8'(1 + $urandom_range(254))));
    endtask

    // Drives up to 'limit' bytes; returns at the falling edge one cycle after the last accept.
    task automatic send_frame(input int limit, input int pct, output int sent);
        int i;
        int pending;
        int cyc;
        int n;
        i = 0;
        pending = -1;
        cyc = 0;
        n = model_n();
        forever begin
            @(negedge clock);
            in_valid = 1'b0;
            if (pending >= 0) begin
                chk("we_pulse", {31'b0, imem_we}, 32'd1);
                chk("wr_addr", imem_addr, 32'(pending * 4));
                chk("wr_data", imem_wdata, model_word(pending));
                pending = -1;
            end else begin
                chk("we_idle", {31'b0, imem_we}, 32'd0);
            end
            if (i >= limit || in_ready !== 1'b1) break;
            if (cyc >= 4000) begin
                checks++;
                errors++;
                $error("FAIL send_timeout observed=%0d bytes expected=%0d bytes", i, limit);
                break;
            end
            cyc++;
            if ($urandom_range(99) < pct) begin
                in_valid = 1'b1;
                in_data  = frame[i];
            end else begin
                in_data = 8'($urandom);
            end
            @(posedge clock);
            if (in_valid) begin
                if (n <= DEPTH && i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
                    pending = (i - 2) / 4;
                i++;
            end
        end
        sent = i;
    endtask

    task automatic check_outcome(input string tag, input int w0);
        logic ok;
        ok = model_ok();
        #1;
        chk({tag, "_done"},     {31'b0, done},     {31'b0, ok});
        chk({tag, "_error"},    {31'b0, error},    {31'b0, ~ok});
        chk({tag, "_hold"},     {31'b0, cpu_hold}, {31'b0, ~ok});
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_nwrites"},  32'(n_writes - w0), 32'(model_writes()));
        $display("frame %s: N=%0d writes=%0d ok=%0b", tag, model_n(), n_writes - w0, ok);
    endtask

    // Restart is pulsed with a valid byte present; it must win and that byte must be dropped.
    task automatic do_restart();
        @(negedge clock);
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clock);
        restart  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("restart_hold",  {31'b0, cpu_hold}, 32'd1);
        chk("restart_ready", {31'b0, in_ready}, 32'd1);
        chk("restart_done",  {31'b0, done},     32'd0);
        chk("restart_error", {31'b0, error},    32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_we"},       {31'b0, imem_we},  32'd0);
        chk({tag, "_addr"},     imem_addr,         32'h0);
        chk({tag, "_wdata"},    imem_wdata,        32'h0);
        chk({tag, "_hold"},     {31'b0, cpu_hold}, 32'd1);
        chk({tag, "_done"},     {31'b0, done},     32'd0);
        chk({tag, "_error"},    {31'b0, error},    32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int w0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        restart  = 1'b0;
        #12;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b1;

        // Good frame, directed
        frame = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h10, 8'h01, 8'hC1};
        w0 = n_writes;
        send_frame(frame.size(), 100, sent);
        check_outcome("good", w0);
        chk("good_last_addr",  imem_addr,  32'h4);
        chk("good_last_wdata", imem_wdata, 32'h01100193);

        // Bad checksum
        do_restart();
        frame[10] = 8'hC0;
        w0 = n_writes;
        send_frame(frame.size(), 100, sent);
        check_outcome("badsum", w0);

        // Oversize header: loader must stop accepting after two bytes
        do_restart();
        frame = '{8'h41, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        w0 = n_writes;
        send_frame(frame.size(), 100, sent);
        chk("oversize_consumed", 32'(sent), 32'd2);
        check_outcome("oversize", w0);

        // Empty image, good and bad checksum
        do_restart();
        frame = '{8'h00, 8'h00, 8'h00};
        w0 = n_writes;
        send_frame(frame.size(), 100, sent);
        check_outcome("n0_good", w0);

        do_restart();
        frame = '{8'h00, 8'h00, 8'h01};
        w0 = n_writes;
        send_frame(frame.size(), 100, sent);
        check_outcome("n0_bad", w0);

        // Backpressure on the directed good frame
        do_restart();
        frame = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h10, 8'h01, 8'hC1};
        w0 = n_writes;
        send_frame(frame.size(), 50, sent);
        check_outcome("backpressure", w0);

        // Random frames, including the exact-capacity boundary
        for (int t = 0; t < 5; t++) begin
            do_restart();
            if (t == 4) build_random(DEPTH, 1'b1);
            else        build_random(int'($urandom_range(1, 8)), (t != 2));
            w0 = n_writes;
            send_frame(frame.size(), 70, sent);
            check_outcome("random", w0);
        end

        // Reset in the middle of the payload, then a clean load
        do_restart();
        frame = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h10, 8'h01, 8'hC1};
        send_frame(6, 100, sent);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clock);
        reset = 1'b1;
        build_random(3, 1'b1);
        w0 = n_writes;
        send_frame(frame.size(), 80, sent);
        check_outcome("after_reset", w0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined RV32 core. It accepts a byte stream over a valid/ready interface, checks a length header and an XOR checksum, and packs the bytes little-endian into 32-bit words. It writes those words into the instruction memory write port and holds the CPU in reset until the image is verified. It is the writing end of the instruction-memory interface; the core's fetch stage is the reading end.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: instruction memory capacity in words.
- `ADDR_W`, 32: width of the byte address driven to IMEM.
- `BASE_ADDR`, 0: byte address of the first word. Must be word aligned.

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte. Transfer occurs when `in_valid && in_ready` at a rising edge.
- `restart`  in  1  single-cycle pulse; re-arms the loader from RUN or ERROR.
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  ADDR_W  byte address; always word aligned.
- `imem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  drives the core's reset (1 = core held).
- `done`  out  1  image loaded and verified.
- `error`  out  1  length or checksum fault.

## Operation
- Frame format:
  - `N_lo`, `N_hi`: 16-bit word count, little-endian.
  - N×4 payload bytes; byte 0 of each word is the LSB.
  - 1 checksum byte, equal to the XOR of all payload bytes.
- States:
  - HDR_LO: accept `N_lo` → HDR_HI.
  - HDR_HI: accept `N_hi`. If N > DEPTH_WORDS → ERROR. If N = 0 → CHECK. Otherwise → PAYLOAD.
  - PAYLOAD: accept bytes and count them. After byte 4N is accepted → CHECK.
  - CHECK: accept 1 byte. If it equals the running XOR → RUN, else → ERROR.
  - RUN: `done`=1, `cpu_hold`=0, `in_ready`=0.
  - ERROR: `error`=1, `cpu_hold`=1, `in_ready`=0.
- `in_ready` = 1 in HDR_LO, HDR_HI, PAYLOAD and CHECK; 0 in RUN and ERROR.
- `restart` in RUN or ERROR → HDR_LO. Word index, byte lane and XOR clear; `cpu_hold` returns to 1 the next cycle. `restart` is ignored in all other states.
- Word k is written to `imem_addr` = BASE_ADDR + 4k. The word index is 16 bits internally. Addresses never wrap, because N ≤ DEPTH_WORDS is enforced.
- Running XOR clears on entry to HDR_LO. It covers payload bytes only.
- Header bytes and the checksum byte never cause IMEM writes.

## Timing
- Reset values:
  - state = HDR_LO, so `in_ready` = 1.
  - `imem_we`=0, `imem_addr`=BASE_ADDR, `imem_wdata`=0.
  - `cpu_hold`=1, `done`=0, `error`=0.
- `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - `imem_we` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
  - `imem_addr` and `imem_wdata` stay stable until the next write.
- Throughput is one byte per cycle with no bubbles. Back-to-back words produce `imem_we` every 4th cycle.
- `done` and `cpu_hold` are registered. Both change in the cycle after the checksum byte is accepted.
  - The last IMEM write of the frame lands at least 1 cycle before `cpu_hold` falls.
- If `in_valid` drops mid-word, the partial word and byte lane are held; no timeout.
- Asserting `reset` mid-frame aborts immediately to the reset values. Words already written stay in IMEM and are not rolled back.
- If `restart` and `in_valid` are both high in RUN, `restart` wins. No byte is accepted that cycle because `in_ready`=0.

## Structure
- `loader_pkg` contains:
  - the state enum: HDR_LO, HDR_HI, PAYLOAD, CHECK, RUN, ERROR;
  - `HDR_BYTES` = 2;
  - `BYTES_PER_WORD` = 4.
- One sub-module, `byte_packer`:
  - 2-bit lane counter and 32-bit shift-in register;
  - asserts `word_valid` when lane 3 is accepted;
  - clears on `restart` or reset.
- The FSM, word counter, XOR accumulator and IMEM output registers live in `imem_loader`.

## Test plan
- Good frame: bytes 02 00 13 01 50 00 93 01 10 01 C1.
  - Writes 0x00500113 @0 and 0x01100193 @4, each with a 1-cycle `imem_we`.
  - Then `done`=1, `cpu_hold`=0, `in_ready`=0.
- Bad checksum: same frame with last byte C0 → both writes occur, then `error`=1, `cpu_hold`=1, `done`=0.
- Oversize header: with DEPTH_WORDS=64, header 41 00 → ERROR after the 2nd byte, no IMEM writes.
- N=0: bytes 00 00 00 → RUN with no writes. With bytes 00 00 01 → ERROR.
- Backpressure and recovery:
  - Toggle `in_valid` randomly during the good frame → identical writes and addresses.
  - Then pulse `restart` → `cpu_hold`=1, `in_ready`=1, and a second frame loads correctly.
- Reset mid-payload: assert `reset` after byte 6 → all outputs take their reset values immediately. A fresh frame after release succeeds.
